vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters: none; burst length fixed at 32 words, VRAM depth fixed at 8192 x 16.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high; clock clk.
REQ-004 cpu_addr  in  13  CPU VRAM word address (CPU address minus 0x4000).
REQ-005 cpu_we  in  1  CPU write strobe, level; honoured only when cpu_busy low.
REQ-006 cpu_wdata  in  16  CPU write data.
REQ-007 cpu_busy  out  1  VRAM not available to CPU; CPU holds address/data while high.
REQ-008 cpu_rdata  out  16  registered RAM read data for the CPU address.
REQ-009 disp_req  in  1  one-cycle pulse requesting a 32-word scanline fetch.
REQ-010 disp_row  in  8  row number, sampled with disp_req.
REQ-011 disp_valid  out  1  disp_data holds one fetched word this cycle.
REQ-012 disp_last  out  1  qualifies the 32nd disp_valid of a burst.
REQ-013 disp_data  out  16  fetched pixel word.
REQ-014 disp_overrun  out  1  sticky: a disp_req arrived while a burst was in progress.
REQ-015 ram_addr  out  13  single-port VRAM address.
REQ-016 ram_we  out  1  VRAM write enable.
REQ-017 ram_wdata  out  16  VRAM write data.
REQ-018 ram_rdata  in  16  VRAM read data, valid one cycle after ram_addr (synchronous read).

Function
REQ-019 FSM states: IDLE (CPU owns RAM), BURST (display issues 32 addresses), DRAIN (last display read returns).
REQ-020 IDLE: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we and not cpu_busy.
REQ-021 IDLE and disp_req high -> latch disp_row, clear 5-bit word counter, next state BURST; display has strict priority.
REQ-022 cpu_busy = (state != IDLE) or (state == IDLE and disp_req); combinational, so a CPU write coincident with disp_req is not performed and is retried by the CPU.
REQ-023 BURST: ram_addr = {row, word}, ram_we=0; word increments each cycle; word==31 -> next state DRAIN.
REQ-024 Display timing: disp_req sampled at edge N -> addresses word 0..31 in cycles N+1..N+32; disp_valid high cycles N+2..N+33 with disp_data=ram_rdata; disp_last high at N+33; DRAIN is cycle N+33; IDLE from N+34.
REQ-025 disp_valid high exactly 32 consecutive cycles per accepted burst; never high in IDLE.
REQ-026 cpu_rdata: registered from ram_rdata on every cycle whose previous cycle was IDLE with cpu_busy low; holds otherwise. CPU read result is valid on the second cycle after cpu_busy falls with stable cpu_addr.
REQ-027 disp_req while in BURST or DRAIN -> request dropped, disp_overrun set; cleared only by reset.
REQ-028 Word counter wraps 31->0 only via new burst; row address never increments across a burst.
REQ-029 No CPU access is lost: a CPU write held during cpu_busy executes in the first IDLE cycle without disp_req.

Reset
REQ-030 reset -> state IDLE, word=0, row=0, disp_valid=0, disp_last=0, disp_overrun=0, cpu_rdata=0; cpu_busy=0 unless disp_req high.
REQ-031 reset mid-burst -> burst aborted immediately, no further disp_valid, no RAM write.
REQ-032 disp_req during the reset cycle is ignored.

Verification
REQ-033 CPU write 0xBEEF to addr 0x0010 in IDLE, then read 0x0010 -> ram_we one cycle; cpu_rdata=0xBEEF two cycles later.
REQ-034 disp_req, disp_row=0x03 with RAM preloaded word i=i -> ram_addr 0x0060..0x007F, 32 disp_valid with data 0x0060..0x007F, disp_last on final word, cpu_busy high 34 cycles.
REQ-035 cpu_we held with addr 0x1FFF, disp_req same cycle -> no write until IDLE at N+34, then exactly one write to 0x1FFF.
REQ-036 Second disp_req at burst word 10 -> disp_overrun=1, first burst completes unchanged, no second burst.
REQ-037 reset asserted at burst word 15 -> disp_valid low from next cycle, state IDLE, cpu_busy low, disp_overrun=0.

Source files
------------

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port 8192 x 16 VRAM between the CPU and the display
// fetcher. The CPU owns the RAM while idle. A one-cycle disp_req takes the RAM
// for a 32-word scanline burst, and the display has strict priority over the
// CPU. The RAM has a synchronous read, so each display word comes back one
// cycle after its address is issued. DRAIN is the cycle in which the last word
// returns.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   cpu_addr        CPU word address into VRAM (13 bits)
//   cpu_we          CPU write strobe (level); honoured only while cpu_busy low
//   cpu_wdata       CPU write data (16 bits)
//   cpu_busy        RAM not available to the CPU; CPU holds address/data
//   cpu_rdata       registered read data for the CPU address
//   disp_req        one-cycle pulse requesting a 32-word scanline fetch
//   disp_row        scanline row, sampled with disp_req
//   disp_valid      disp_data carries one fetched word this cycle
//   disp_last       marks the 32nd word of a burst
//   disp_data       fetched pixel word
//   disp_overrun    sticky flag: disp_req arrived while a burst was running
//   ram_addr/ram_we/ram_wdata   single-port VRAM request
//   ram_rdata       VRAM read data, one cycle after ram_addr
// -----------------------------------------------------------------------------
module vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_busy,
  output logic [15:0] cpu_rdata,
  input  logic        disp_req,
  input  logic [7:0]  disp_row,
  output logic        disp_valid,
  output logic        disp_last,
  output logic [15:0] disp_data,
  output logic        disp_overrun,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  row;
  logic [4:0]  word;
  logic        cpu_slot;    // CPU really owns the RAM this cycle
  logic        cpu_slot_q;  // ram_rdata now answers a CPU address

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order of the statements.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cpu_busy   = 1'b1;
    cpu_slot   = 1'b0;
    ram_addr   = {row, word};
    ram_we     = 1'b0;
    disp_last  = 1'b0;
    unique case (state)
      IDLE: begin
        // disp_req pre-empts the CPU in the same cycle. A coincident CPU
        // write is suppressed, and the CPU retries it because cpu_busy is high.
        cpu_busy = disp_req;
        cpu_slot = ~disp_req;
        ram_addr = cpu_addr;
        ram_we   = cpu_we & ~disp_req;
        if (disp_req) state_next = BURST;
      end
      BURST: begin
        if (word == 5'd31) state_next = DRAIN;
      end
      DRAIN: begin
        // The word addressed in the last BURST cycle is on ram_rdata now.
        disp_last  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_wdata = cpu_wdata;
  assign disp_data = ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      row          <= '0;
      word         <= '0;
      disp_valid   <= 1'b0;
      disp_overrun <= 1'b0;
      cpu_slot_q   <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      // Read data trails the address by one cycle. Every BURST cycle
      // therefore yields a valid word in the following cycle.
      disp_valid <= (state == BURST);
      cpu_slot_q <= cpu_slot;
      if (cpu_slot_q) cpu_rdata <= ram_rdata;

      if (state == IDLE && disp_req) begin
        row  <= disp_row;
        word <= '0;
      end else if (state == BURST && word != 5'd31) begin
        // word holds at 31 through DRAIN. Only the next burst restarts it.
        word <= word + 5'd1;
      end

      if (state != IDLE && disp_req) disp_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter. A behavioural VRAM with a synchronous,
// read-first port is attached to the ram_* pins. The reference model predicts
// each cycle from the arbitration rules, in terms of the cycle in which a
// burst was accepted. It has a private copy of the memory contents and a
// two-cycle CPU read pipeline. Directed scenarios are followed by random
// traffic.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic        cpu_busy;
  logic [15:0] cpu_rdata;
  logic        disp_req;
  logic [7:0]  disp_row;
  logic        disp_valid;
  logic        disp_last;
  logic [15:0] disp_data;
  logic        disp_overrun;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  vram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_wdata    (cpu_wdata),
    .cpu_busy     (cpu_busy),
    .cpu_rdata    (cpu_rdata),
    .disp_req     (disp_req),
    .disp_row     (disp_row),
    .disp_valid   (disp_valid),
    .disp_last    (disp_last),
    .disp_data    (disp_data),
    .disp_overrun (disp_overrun),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural VRAM: synchronous read-first port.
  logic [15:0] vram [8192];
  int          wr_1fff = 0;
  always @(posedge clk) begin
    if (ram_we) begin
      vram[ram_addr] <= ram_wdata;
      if (ram_addr == 13'h1fff) wr_1fff <= wr_1fff + 1;
    end
    ram_rdata <= vram[ram_addr];
  end

  // Reference model state.
  logic [15:0] ref_mem [8192];
  int          cyc    = 0;
  int          acc_c  = -1;   // cycle in which the current burst was accepted
  logic [7:0]  m_row  = '0;
  logic        m_ovr  = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        p_v    = 1'b0; // CPU read issued last cycle
  logic [15:0] p_val  = '0;
  logic        known  = 1'b0; // DUT has seen a reset edge

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0, valid_cnt = 0, last_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model.
  task automatic step(input logic rst, input logic req, input logic [7:0] row,
                      input logic we, input logic [12:0] addr,
                      input logic [15:0] wd);
    logic        in_use, e_busy, e_we, e_valid, e_last;
    logic [15:0] rd_now;
    reset = rst; disp_req = req; disp_row = row;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    in_use  = (acc_c >= 0) && (cyc >= acc_c + 1) && (cyc <= acc_c + 33);
    e_busy  = in_use || req;
    e_we    = !in_use && !req && we;
    e_valid = (acc_c >= 0) && (cyc >= acc_c + 2) && (cyc <= acc_c + 33);
    e_last  = (acc_c >= 0) && (cyc == acc_c + 33);
    @(negedge clk);
    if (cpu_busy === 1'b1) busy_cnt++;
    if (disp_valid === 1'b1) valid_cnt++;
    if (disp_last === 1'b1) last_cnt++;
    if (known) begin
      check("cpu_busy", 32'(cpu_busy), 32'(e_busy));
      check("ram_we", 32'(ram_we), 32'(e_we));
      if (e_we) check("ram_wdata", 32'(ram_wdata), 32'(wd));
      if (!in_use)
        check("ram_addr_cpu", 32'(ram_addr), 32'(addr));
      else if (cyc <= acc_c + 32)
        check("ram_addr_burst", 32'(ram_addr),
              32'({m_row, 5'(cyc - acc_c - 1)}));
      check("disp_valid", 32'(disp_valid), 32'(e_valid));
      check("disp_last", 32'(disp_last), 32'(e_last));
      check("disp_overrun", 32'(disp_overrun), 32'(m_ovr));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
      if (e_valid)
        check("disp_data", 32'(disp_data),
              32'(ref_mem[{m_row, 5'(cyc - acc_c - 2)}]));
    end
    // Advance the model across the clock edge.
    rd_now = ref_mem[addr];
    if (e_we) ref_mem[addr] = wd;  // the RAM write ignores reset
    if (rst) begin
      acc_c = -1; m_ovr = 1'b0; m_rdata = '0; p_v = 1'b0;
      known = 1'b1;
    end else begin
      if (p_v) m_rdata = p_val;
      p_v   = !in_use && !req;
      p_val = rd_now;
      if (!in_use && req) begin
        acc_c = cyc; m_row = row;
      end else if (in_use && req) begin
        m_ovr = 1'b1;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 13'h0000, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      vram[i]    = 16'(i);
      ref_mem[i] = 16'(i);
    end
    reset = 1'b1; disp_req = 1'b0; disp_row = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk); #1;

    // Reset. The disp_req during the second reset cycle must be ignored.
    step(1'b1, 1'b0, 8'h00, 1'b0, 13'h0000, 16'h0000);
    step(1'b1, 1'b1, 8'h44, 1'b0, 13'h0000, 16'h0000);
    idle(3);
    check("reset_overrun", 32'(disp_overrun), 32'd0);
    check("reset_rdata", 32'(cpu_rdata), 32'd0);

    // CPU write 0xBEEF to 0x0010, then read it back.
    step(1'b0, 1'b0, 8'h00, 1'b1, 13'h0010, 16'hBEEF);
    step(1'b0, 1'b0, 8'h00, 1'b0, 13'h0010, 16'h0000);
    step(1'b0, 1'b0, 8'h00, 1'b0, 13'h0010, 16'h0000);
    step(1'b0, 1'b0, 8'h00, 1'b0, 13'h0010, 16'h0000);
    check("beef_readback", 32'(cpu_rdata), 32'h0000BEEF);

    // Row 3 burst with a CPU write to 0x1FFF held from the same cycle.
    busy_cnt = 0; valid_cnt = 0; last_cnt = 0; wr_1fff = 0;
    step(1'b0, 1'b1, 8'h03, 1'b1, 13'h1fff, 16'h5A5A);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 13'h1fff, 16'h5A5A);
    check("held_write_blocked", 32'(wr_1fff), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 13'h1fff, 16'h5A5A);
    idle(4);
    check("held_write_once", 32'(wr_1fff), 32'd1);
    check("burst_busy_cycles", 32'(busy_cnt), 32'd34);
    check("burst_valid_count", 32'(valid_cnt), 32'd32);
    check("burst_last_count", 32'(last_cnt), 32'd1);

    // A second disp_req at word 10 is dropped and flags an overrun.
    valid_cnt = 0;
    step(1'b0, 1'b1, 8'h05, 1'b0, 13'h0000, 16'h0000);
    idle(10);
    step(1'b0, 1'b1, 8'h09, 1'b0, 13'h0000, 16'h0000);
    idle(40);
    check("overrun_set", 32'(disp_overrun), 32'd1);
    check("overrun_single_burst", 32'(valid_cnt), 32'd32);

    // Reset at word 15 aborts the burst and clears the overrun flag.
    step(1'b0, 1'b1, 8'h02, 1'b0, 13'h0000, 16'h0000);
    idle(15);
    step(1'b1, 1'b0, 8'h00, 1'b0, 13'h0000, 16'h0000);
    check("abort_valid", 32'(disp_valid), 32'd0);
    check("abort_busy", 32'(cpu_busy), 32'd0);
    check("abort_overrun", 32'(disp_overrun), 32'd0);
    valid_cnt = 0;
    idle(40);
    check("abort_no_more_valid", 32'(valid_cnt), 32'd0);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      logic        r_rst, r_req, r_we;
      logic [12:0] r_addr;
      r_rst  = ($urandom_range(0, 599) == 0);
      r_req  = ($urandom_range(0, 24) == 0);
      r_we   = ($urandom_range(0, 2) == 0);
      r_addr = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 8191))
                                           : 13'($urandom_range(0, 63));
      step(r_rst, r_req, 8'($urandom_range(0, 255)), r_we, r_addr,
           16'($urandom));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
